// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap/return sequencer.
package trap_pkg;

  // Sequencer states, one per CSR access plus the redirect handshake.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    T_RDST  = 4'd1,
    T_EPC   = 4'd2,
    T_CAUSE = 4'd3,
    T_TVAL  = 4'd4,
    T_WRST  = 4'd5,
    T_RDVEC = 4'd6,
    R_RDST  = 4'd7,
    R_WRST  = 4'd8,
    R_RDEPC = 4'd9,
    REDIR   = 4'd10
  } trap_state_t;

  // Machine-mode CSR addresses touched by the sequence.
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Interrupt codes (bit positions in mip/mie).
  localparam logic [3:0] IRQ_SSI = 4'd1;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_STI = 4'd5;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_SEI = 4'd9;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // Priority order, index 0 is the highest priority.
  localparam int IRQ_NUM = 6;
  localparam logic [3:0] IRQ_PRIO [IRQ_NUM] = '{IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI};

  // mstatus bit positions.
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mstatus image written on trap entry: stack MIE into MPIE, enter M-mode, disable.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] st);
    logic [31:0] r;
    r = st;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    r[MSTATUS_MPIE] = st[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // mstatus image written on mret: restore MIE from MPIE, MPIE set, MPP to U.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] st);
    logic [31:0] r;
    r = st;
    r[MSTATUS_MIE]  = st[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer_irq_prio_enc.sv
// Fixed-priority interrupt encoder; bits outside the priority list are ignored.
module irq_prio_enc
  import trap_pkg::*;
(
  input  logic [11:0] pending,
  output logic [3:0]  code,
  output logic        valid
);

  // Scan lowest priority first so the highest-priority pending code wins last.
  always_comb begin
    code  = 4'd0;
    valid = 1'b0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (pending[IRQ_PRIO[i]]) begin
        code  = IRQ_PRIO[i];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer sitting in front of the csr_file access port.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | pass pipeline CSR accesses through, arbitrate requests
// T_RDST  | read mstatus into st
// T_EPC   | write mepc
// T_CAUSE | write mcause
// T_TVAL  | write mtval (0 for interrupts)
// T_WRST  | write mstatus with trap-entry stacking
// T_RDVEC | read mtvec, form redirect target
// R_RDST  | read mstatus into st
// R_WRST  | write mstatus with mret unstacking
// R_RDEPC | read mepc, form redirect target
// REDIR   | hold redirect until fetch accepts it
module trap_sequencer
  import trap_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset,
  input  logic        exc_valid,
  output logic        exc_ready,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  output logic        mret_ready,
  input  logic [11:0] irq_pending,
  input  logic        ctrl_mie,
  input  logic [11:0] ins_addr,
  input  logic [31:0] ins_wdata,
  input  logic        ins_wen,
  output logic        ins_gnt,
  output logic [31:0] ins_rdata,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_wen,
  input  logic [31:0] csr_rdata,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  trap_state_t state;

  logic [31:0] st;
  logic [31:0] epc;
  logic [31:0] tval;
  logic [3:0]  cause;
  logic        is_irq;

  logic [3:0]  irq_code;
  logic        irq_valid;

  logic        idle;
  logic        irq_req;
  logic        take_exc;
  logic        take_irq;
  logic        take_mret;
  logic        accept;

  logic [31:0] vec_base;
  logic [31:0] vec_target;

  irq_prio_enc u_irq_prio_enc (
    .pending (irq_pending),
    .code    (irq_code),
    .valid   (irq_valid)
  );

  // Arbitration in IDLE: exception, then enabled interrupt, then mret, else pass-through.
  always_comb begin
    idle       = (state == IDLE) && !ctrl_reset;
    irq_req    = ctrl_mie && irq_valid;
    take_exc   = idle && exc_valid;
    take_irq   = idle && !exc_valid && irq_req;
    take_mret  = idle && !exc_valid && !irq_req && mret_valid;
    accept     = take_exc || take_irq || take_mret;
    exc_ready  = take_exc;
    mret_ready = take_mret;
    ins_gnt    = idle && !accept;
    ins_rdata  = csr_rdata;
  end

  // Trap target from mtvec: vectored mode only offsets interrupts.
  always_comb begin
    vec_base   = {csr_rdata[31:2], 2'b00};
    vec_target = vec_base;
    if (csr_rdata[1:0] == 2'b01 && is_irq) begin
      vec_target = vec_base + {26'd0, cause, 2'b00};
    end
  end

  // CSR port mux: pipeline access in IDLE, otherwise the current sequence step.
  always_comb begin
    csr_addr  = 12'd0;
    csr_wdata = 32'd0;
    csr_wen   = 1'b0;
    case (state)
      IDLE: begin
        if (ins_gnt) begin
          csr_addr  = ins_addr;
          csr_wdata = ins_wdata;
          csr_wen   = ins_wen;
        end
      end
      T_RDST, R_RDST: csr_addr = CSR_MSTATUS;
      T_EPC: begin
        csr_addr  = CSR_MEPC;
        csr_wdata = epc & ~32'd3;
        csr_wen   = 1'b1;
      end
      T_CAUSE: begin
        csr_addr  = CSR_MCAUSE;
        csr_wdata = {is_irq, 27'd0, cause};
        csr_wen   = 1'b1;
      end
      T_TVAL: begin
        csr_addr  = CSR_MTVAL;
        csr_wdata = is_irq ? 32'd0 : tval;
        csr_wen   = 1'b1;
      end
      T_WRST: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_trap(st);
        csr_wen   = 1'b1;
      end
      T_RDVEC: csr_addr = CSR_MTVEC;
      R_WRST: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_mret(st);
        csr_wen   = 1'b1;
      end
      R_RDEPC: csr_addr = CSR_MEPC;
      default: begin
        csr_addr  = 12'd0;
        csr_wdata = 32'd0;
        csr_wen   = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered redirect and busy outputs.
  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state          <= IDLE;
      st             <= 32'd0;
      epc            <= 32'd0;
      tval           <= 32'd0;
      cause          <= 4'd0;
      is_irq         <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_exc) begin
            cause  <= exc_cause;
            epc    <= exc_pc;
            tval   <= exc_tval;
            is_irq <= 1'b0;
            state  <= T_RDST;
            busy   <= 1'b1;
          end else if (take_irq) begin
            cause  <= irq_code;
            epc    <= exc_pc;
            tval   <= 32'd0;
            is_irq <= 1'b1;
            state  <= T_RDST;
            busy   <= 1'b1;
          end else if (take_mret) begin
            state  <= R_RDST;
            busy   <= 1'b1;
          end
        end
        T_RDST: begin
          st    <= csr_rdata;
          state <= T_EPC;
        end
        T_EPC:   state <= T_CAUSE;
        T_CAUSE: state <= T_TVAL;
        T_TVAL:  state <= T_WRST;
        T_WRST:  state <= T_RDVEC;
        T_RDVEC: begin
          redirect_pc    <= vec_target;
          redirect_valid <= 1'b1;
          state          <= REDIR;
        end
        R_RDST: begin
          st    <= csr_rdata;
          state <= R_WRST;
        end
        R_WRST: state <= R_RDEPC;
        R_RDEPC: begin
          redirect_pc    <= csr_rdata & ~32'd3;
          redirect_valid <= 1'b1;
          state          <= REDIR;
        end
        REDIR: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a small behavioural csr_file.
module tb_trap_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        ctrl_clk;
  logic        ctrl_reset;
  logic        exc_valid;
  logic        exc_ready;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        mret_ready;
  logic [11:0] irq_pending;
  logic        ctrl_mie;
  logic [11:0] ins_addr;
  logic [31:0] ins_wdata;
  logic        ins_wen;
  logic        ins_gnt;
  logic [31:0] ins_rdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        busy;

  int passed = 0;
  int total  = 0;

  trap_sequencer #(.RESET_PC(RST_PC)) dut (
    .ctrl_clk       (ctrl_clk),
    .ctrl_reset     (ctrl_reset),
    .exc_valid      (exc_valid),
    .exc_ready      (exc_ready),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret_valid     (mret_valid),
    .mret_ready     (mret_ready),
    .irq_pending    (irq_pending),
    .ctrl_mie       (ctrl_mie),
    .ins_addr       (ins_addr),
    .ins_wdata      (ins_wdata),
    .ins_wen        (ins_wen),
    .ins_gnt        (ins_gnt),
    .ins_rdata      (ins_rdata),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_wen        (csr_wen),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // CSR file stand-in; never reset, so completed writes survive ctrl_reset.
  logic [31:0] m_status, m_tvec, m_epc, m_cause, m_tval, m_scratch;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = m_status;
      12'h305: csr_rdata = m_tvec;
      12'h340: csr_rdata = m_scratch;
      12'h341: csr_rdata = m_epc;
      12'h342: csr_rdata = m_cause;
      12'h343: csr_rdata = m_tval;
      default: csr_rdata = 32'd0;
    endcase
  end

  always @(posedge ctrl_clk) begin
    if (csr_wen) begin
      case (csr_addr)
        12'h300: m_status  <= csr_wdata;
        12'h305: m_tvec    <= csr_wdata;
        12'h340: m_scratch <= csr_wdata;
        12'h341: m_epc     <= csr_wdata;
        12'h342: m_cause   <= csr_wdata;
        12'h343: m_tval    <= csr_wdata;
        default: ;
      endcase
    end
  end

  assign ctrl_mie = m_status[3];

  initial ctrl_clk = 1'b0;
  always #5 ctrl_clk = ~ctrl_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    ins_addr  = a;
    ins_wdata = d;
    ins_wen   = 1'b1;
    tick();
    ins_wen   = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    ins_addr = a;
    ins_wen  = 1'b0;
    #1;
    d = ins_rdata;
  endtask

  // Called in the accept cycle; returns cycles until redirect_valid (bounded).
  task automatic wait_redir(output int cyc);
    cyc = 0;
    while (!redirect_valid && cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        exc_valid   = 1'b0;
        irq_pending = 12'd0;
        ins_wen     = 1'b0;
      end
    end
  endtask

  task automatic finish_redir(input string tag);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rv_after"}, {31'd0, redirect_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  int lat;

  initial begin
    exc_valid = 1'b0; exc_cause = 4'd0; exc_pc = 32'd0; exc_tval = 32'd0;
    mret_valid = 1'b0; irq_pending = 12'd0;
    ins_addr = 12'd0; ins_wdata = 32'd0; ins_wen = 1'b0;
    redirect_ready = 1'b0;

    // Reset values, with requests present during reset.
    ctrl_reset = 1'b1;
    exc_valid  = 1'b1;
    ins_wen    = 1'b1;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_pc", redirect_pc, RST_PC);
    chk("rst_exc_ready", {31'd0, exc_ready}, 32'd0);
    chk("rst_csr_wen", {31'd0, csr_wen}, 32'd0);
    exc_valid = 1'b0;
    ins_wen   = 1'b0;
    tick();
    tick();
    ctrl_reset = 1'b0;
    tick();

    // Exception: cause 2, pc 0x100, tval 0xDEAD, direct mtvec.
    csr_write(12'h300, 32'h0000_0008);
    csr_write(12'h305, 32'h0000_2000);
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    #1;
    chk("exc_ready", {31'd0, exc_ready}, 32'd1);
    chk("exc_ins_gnt", {31'd0, ins_gnt}, 32'd0);
    wait_redir(lat);
    chk("exc_latency", lat, 7);
    chk("exc_redir_pc", redirect_pc, 32'h2000);
    tick();
    tick();
    chk("exc_stall_rv", {31'd0, redirect_valid}, 32'd1);
    chk("exc_stall_pc", redirect_pc, 32'h2000);
    chk("exc_stall_busy", {31'd0, busy}, 32'd1);
    finish_redir("exc");
    csr_read(12'h341, rd); chk("exc_mepc", rd, 32'h100);
    csr_read(12'h342, rd); chk("exc_mcause", rd, 32'h2);
    csr_read(12'h343, rd); chk("exc_mtval", rd, 32'hDEAD);
    csr_read(12'h300, rd);
    chk("exc_mie", {31'd0, rd[3]}, 32'd0);
    chk("exc_mpie", {31'd0, rd[7]}, 32'd1);
    chk("exc_mpp", {30'd0, rd[12:11]}, 32'd3);

    // Vectored interrupt: pending 11 and 7, 11 wins.
    csr_write(12'h300, 32'h0000_0008);
    csr_write(12'h305, 32'h0000_2001);
    exc_pc = 32'h200;
    irq_pending = 12'h880;
    #1;
    chk("irq_ins_gnt", {31'd0, ins_gnt}, 32'd0);
    chk("irq_mret_ready", {31'd0, mret_ready}, 32'd0);
    wait_redir(lat);
    chk("irq_latency", lat, 7);
    chk("irq_redir_pc", redirect_pc, 32'h202C);
    finish_redir("irq");
    csr_read(12'h342, rd); chk("irq_mcause", rd, 32'h8000_000B);
    csr_read(12'h343, rd); chk("irq_mtval", rd, 32'h0);
    csr_read(12'h341, rd); chk("irq_mepc", rd, 32'h200);
    csr_read(12'h300, rd); chk("irq_mstatus", rd, 32'h1880);

    // Masked interrupt: MIE=0 now, pending present, pass-through still served.
    irq_pending = 12'h080;
    ins_addr = 12'h340; ins_wdata = 32'h1234_5678; ins_wen = 1'b1;
    #1;
    chk("mask_gnt", {31'd0, ins_gnt}, 32'd1);
    chk("mask_csr_wen", {31'd0, csr_wen}, 32'd1);
    tick();
    ins_wen = 1'b0;
    chk("mask_busy", {31'd0, busy}, 32'd0);
    csr_read(12'h340, rd); chk("mask_mscratch", rd, 32'h1234_5678);
    irq_pending = 12'd0;

    // mret with mepc = 0x104.
    csr_write(12'h341, 32'h104);
    mret_valid = 1'b1;
    #1;
    chk("mret_ready", {31'd0, mret_ready}, 32'd1);
    wait_redir(lat);
    mret_valid = 1'b0;
    chk("mret_latency", lat, 4);
    chk("mret_redir_pc", redirect_pc, 32'h104);
    finish_redir("mret");
    csr_read(12'h300, rd); chk("mret_mstatus", rd, 32'h0088);

    // Simultaneous exception, mret and pipeline write.
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h300; exc_tval = 32'h55;
    mret_valid = 1'b1;
    ins_addr = 12'h340; ins_wdata = 32'hBAD; ins_wen = 1'b1;
    #1;
    chk("sim_exc_ready", {31'd0, exc_ready}, 32'd1);
    chk("sim_mret_ready", {31'd0, mret_ready}, 32'd0);
    chk("sim_ins_gnt", {31'd0, ins_gnt}, 32'd0);
    chk("sim_csr_wen", {31'd0, csr_wen}, 32'd0);
    wait_redir(lat);
    chk("sim_latency", lat, 7);
    chk("sim_redir_pc", redirect_pc, 32'h2000);
    chk("sim_busy_mret_ready", {31'd0, mret_ready}, 32'd0);
    finish_redir("sim_exc");
    chk("sim_mret_accept", {31'd0, mret_ready}, 32'd1);
    wait_redir(lat);
    mret_valid = 1'b0;
    chk("sim_mret_latency", lat, 4);
    chk("sim_mret_pc", redirect_pc, 32'h300);
    finish_redir("sim_mret");
    csr_read(12'h340, rd); chk("sim_mscratch", rd, 32'h1234_5678);
    csr_read(12'h343, rd); chk("sim_mtval", rd, 32'h55);
    csr_read(12'h342, rd); chk("sim_mcause", rd, 32'h5);

    // Reset during T_CAUSE: mepc written, mcause untouched, no redirect.
    exc_valid = 1'b1; exc_cause = 4'd6; exc_pc = 32'h400; exc_tval = 32'h77;
    tick();
    exc_valid = 1'b0;
    tick();
    tick();
    ctrl_reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("mid_rst_pc", redirect_pc, RST_PC);
    chk("mid_rst_csr_wen", {31'd0, csr_wen}, 32'd0);
    tick();
    ctrl_reset = 1'b0;
    tick();
    tick();
    chk("mid_rst_no_redir", {31'd0, redirect_valid}, 32'd0);
    csr_read(12'h341, rd); chk("mid_rst_mepc", rd, 32'h400);
    csr_read(12'h342, rd); chk("mid_rst_mcause", rd, 32'h5);
    csr_read(12'h300, rd); chk("mid_rst_mstatus", rd, 32'h0088);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
